// File: rtl/rw_sched_pkg.sv
// Shared types for the read/write request scheduler: FSM states, grant kinds
// and the strobe-age timer width.
package rw_sched_pkg;

  localparam int TMR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RD_ACT,
    WR_ACT,
    GAP
  } rw_state_e;

  typedef enum logic {
    KIND_RD,
    KIND_WR
  } rw_kind_e;

endpackage

// File: rtl/rw_pend_cnt.sv
// Saturating pending-request counter with a sticky overflow flag.
// A request arriving at the limit is dropped unless an issue frees a slot in the same cycle.
module rw_pend_cnt #(
  parameter int MAX_PEND = 7,
  parameter int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] cnt,
  output logic          ovf
);

  localparam logic [PW-1:0] CNT_MAX = PW'(MAX_PEND);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!inc && dec && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/rw_req_scheduler.sv
// Issues queued read/write requests one at a time with a service timeout.
// Optional timeout error counter enabled by defining RW_SCHED_ERRCNT_EN.
module rw_req_scheduler
  import rw_sched_pkg::*;
#(
  parameter int TIMEOUT  = 5,
  parameter int MAX_PEND = 7,
  parameter int PW       = $clog2(MAX_PEND + 1),
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic             rd_served,
  input  logic             wr_served,
  output logic             read,
  output logic             write,
  output logic             interrupt,
  output logic             busy,
  output logic [PW-1:0]    rd_pend,
  output logic [PW-1:0]    wr_pend,
  output logic             ovf,
  output logic [ERR_W-1:0] err_cnt
);

  // Handshake: a strobe stays high until its matching served is sampled at
  // strobe age 1..TIMEOUT-1; otherwise interrupt pulses at age TIMEOUT and the
  // strobe drops on the following cycle. One GAP cycle always separates strobes.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_WARN = TMR_W'(TIMEOUT - 1);

  rw_state_e        state_q, state_d;
  rw_kind_e         last_kind_q, last_kind_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             interrupt_q, interrupt_d;
  logic             rd_issue, wr_issue;
  logic             rd_ovf, wr_ovf;
  logic             served;

  rw_pend_cnt #(.MAX_PEND(MAX_PEND), .PW(PW)) u_rd_pend (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (rd_req),
    .dec  (rd_issue),
    .cnt  (rd_pend),
    .ovf  (rd_ovf)
  );

  rw_pend_cnt #(.MAX_PEND(MAX_PEND), .PW(PW)) u_wr_pend (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (wr_req),
    .dec  (wr_issue),
    .cnt  (wr_pend),
    .ovf  (wr_ovf)
  );

  always_comb begin
    state_d     = state_q;
    last_kind_d = last_kind_q;
    timer_d     = timer_q;
    read_d      = read_q;
    write_d     = write_q;
    interrupt_d = 1'b0;
    rd_issue    = 1'b0;
    wr_issue    = 1'b0;
    served      = (state_q == RD_ACT && rd_served) || (state_q == WR_ACT && wr_served);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        // Reads win a tie unless the previous grant was a read.
        if (rd_pend != '0 && (wr_pend == '0 || last_kind_q == KIND_WR)) begin
          state_d     = RD_ACT;
          read_d      = 1'b1;
          rd_issue    = 1'b1;
          last_kind_d = KIND_RD;
        end else if (wr_pend != '0) begin
          state_d     = WR_ACT;
          write_d     = 1'b1;
          wr_issue    = 1'b1;
          last_kind_d = KIND_WR;
        end
      end
      RD_ACT, WR_ACT: begin
        if (timer_q == TMR_LAST || (served && timer_q != '0)) begin
          state_d = GAP;
          read_d  = 1'b0;
          write_d = 1'b0;
          timer_d = '0;
        end else begin
          timer_d     = timer_q + 1'b1;
          interrupt_d = (timer_q == TMR_WARN);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_kind_q <= KIND_WR;
      timer_q     <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_kind_q <= last_kind_d;
      timer_q     <= timer_d;
      read_q      <= read_d;
      write_q     <= write_d;
      interrupt_q <= interrupt_d;
    end
  end

  assign read      = read_q;
  assign write     = write_q;
  assign interrupt = interrupt_q;
  assign busy      = (state_q != IDLE);
  assign ovf       = rd_ovf | wr_ovf;

`ifdef RW_SCHED_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (interrupt_d && err_cnt_q != '1) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rw_req_scheduler.sv
// Bench for rw_req_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a request-level model.
module tb_rw_req_scheduler;

  localparam int TIMEOUT  = 5;
  localparam int MAX_PEND = 7;
  localparam int ERR_MAX  = 255;
  localparam int EXP_W    = 19;
`ifdef RW_SCHED_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       intr;
    logic       busy;
    logic [2:0] rp;
    logic [2:0] wp;
    logic       ov;
    logic [7:0] err;
  } exp_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic       wr_req = 1'b0;
  logic       rd_served = 1'b0;
  logic       wr_served = 1'b0;
  logic       read, write, interrupt, busy, ovf;
  logic [2:0] rd_pend, wr_pend;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  rw_req_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .rd_served(rd_served),
    .wr_served(wr_served),
    .read     (read),
    .write    (write),
    .interrupt(interrupt),
    .busy     (busy),
    .rd_pend  (rd_pend),
    .wr_pend  (wr_pend),
    .ovf      (ovf),
    .err_cnt  (err_cnt)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rd_req = 1'b0;
    wr_req = 1'b0;
    rst_n  = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Memory-side responder: answers a strobe after a chosen age, plus optional noise.
  int resp_en  = 0;
  int fix_dly  = -1;
  int noise_en = 0;
  int rd_age = 0, wr_age = 0, rd_dly = 0, wr_dly = 0;
  bit prev_rd = 0, prev_wr = 0;

  always @(posedge clk) begin
    #2;
    if (read && !prev_rd) begin
      rd_age = 0;
      rd_dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 7));
    end else if (read) begin
      rd_age++;
    end
    if (write && !prev_wr) begin
      wr_age = 0;
      wr_dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 7));
    end else if (write) begin
      wr_age++;
    end
    prev_rd = read;
    prev_wr = write;
    rd_served = (resp_en != 0) &&
                ((read && rd_age == rd_dly) || (noise_en != 0 && $urandom_range(0, 15) == 0));
    wr_served = (resp_en != 0) &&
                ((write && wr_age == wr_dly) || (noise_en != 0 && $urandom_range(0, 15) == 0));
  end

  // ---------------- behavioural model ----------------
  // Request-level view: the active job (none/read/write) and its strobe age,
  // a one-cycle gap after every job, and plain integer pending counts.
  logic [EXP_W-1:0] exp_q[$];
  int m_rd, m_wr, m_kind, m_age, m_err;
  bit m_ovf, m_gap, m_last_wr, m_int;

  function automatic void pend_upd(inout int p, inout bit ov, input bit req, input bit iss);
    if (req && !iss) begin
      if (p == MAX_PEND) ov = 1'b1;
      else p++;
    end else if (!req && iss) begin
      p--;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit rd_iss, wr_iss, fire, srv;
    exp_t e;
    if (!rst_n) begin
      m_rd = 0; m_wr = 0; m_kind = 0; m_age = 0; m_err = 0;
      m_ovf = 0; m_gap = 0; m_last_wr = 1; m_int = 0;
      exp_q.delete();
    end else begin
      rd_iss = 0; wr_iss = 0; fire = 0;
      if (m_kind != 0) begin
        srv = (m_kind == 1) ? rd_served : wr_served;
        if ((srv && m_age >= 1 && m_age < TIMEOUT) || m_age == TIMEOUT) begin
          m_kind = 0;
          m_gap  = 1;
        end else begin
          fire = (m_age == TIMEOUT - 1);
          m_age++;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (m_rd > 0 && (m_wr == 0 || m_last_wr)) begin
        m_kind = 1; m_age = 0; rd_iss = 1; m_last_wr = 0;
      end else if (m_wr > 0) begin
        m_kind = 2; m_age = 0; wr_iss = 1; m_last_wr = 1;
      end
      pend_upd(m_rd, m_ovf, rd_req, rd_iss);
      pend_upd(m_wr, m_ovf, wr_req, wr_iss);
      if (fire && m_err < ERR_MAX) m_err++;
      m_int = fire;
      e.rd   = (m_kind == 1);
      e.wr   = (m_kind == 2);
      e.intr = m_int;
      e.busy = (m_kind != 0) || m_gap;
      e.rp   = 3'(m_rd);
      e.wp   = 3'(m_wr);
      e.ov   = m_ovf;
      e.err  = ERR_EN ? 8'(m_err) : 8'd0;
      exp_q.push_back(e);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : compare
    exp_t e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      check("read", read, e.rd);
      check("write", write, e.wr);
      check("interrupt", interrupt, e.intr);
      check("busy", busy, e.busy);
      check("rd_pend", rd_pend, e.rp);
      check("wr_pend", wr_pend, e.wp);
      check("ovf", ovf, e.ov);
      check("err_cnt", err_cnt, e.err);
      check("no_overlap", read && write, 0);
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    int first, last, hi, int_c, ints, wfirst, whi, strobes;
    bit done;

    repeat (2) @(posedge clk);
    #2;
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_pend", rd_pend, 0);
    check("rst_wr_pend", wr_pend, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    cyc();

    // Single read served at strobe age 3: read high in cycles 2..5.
    resp_en = 1; fix_dly = 3; noise_en = 0;
    first = -1; last = -1; ints = 0;
    rd_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (read) begin
        if (first < 0) first = c;
        last = c;
      end
      if (interrupt) ints++;
      cyc();
      rd_req = 1'b0;
    end
    check("t1_read_rise", first, 2);
    check("t1_read_fall", last, 5);
    check("t1_rd_pend", rd_pend, 0);
    check("t1_no_interrupt", ints, 0);

    // Write never served: six strobe cycles, interrupt at age 5.
    do_reset();
    resp_en = 0;
    first = -1; last = -1; int_c = -1;
    wr_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (write) begin
        if (first < 0) first = c;
        last = c;
      end
      if (interrupt) int_c = c;
      cyc();
      wr_req = 1'b0;
    end
    check("t2_write_rise", first, 2);
    check("t2_write_len", last - first + 1, 6);
    check("t2_int_age", int_c - first, 5);
    check("t2_err_cnt", err_cnt, ERR_EN ? 1 : 0);
    check("t2_model_err", m_err, 1);

    // Simultaneous read and write, each served at age 1: read, gap, idle, write.
    do_reset();
    resp_en = 1; fix_dly = 1;
    first = -1; hi = 0; wfirst = -1; whi = 0;
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (read) begin
        if (first < 0) first = c;
        hi++;
      end
      if (write) begin
        if (wfirst < 0) wfirst = c;
        whi++;
      end
      cyc();
      rd_req = 1'b0;
      wr_req = 1'b0;
    end
    check("t3_read_rise", first, 2);
    check("t3_read_len", hi, 2);
    check("t3_write_rise", wfirst, 6);
    check("t3_write_len", whi, 2);

    // Nine back-to-back reads, no service: one issues at once, seven queue, one is lost.
    do_reset();
    resp_en = 0;
    for (int i = 0; i < 9; i++) begin
      rd_req = 1'b1;
      cyc();
    end
    rd_req = 1'b0;
    check("t4_rd_pend_sat", rd_pend, 7);
    check("t4_ovf", ovf, 1);
    check("t4_model_pend", m_rd, 7);
    ints = 0;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (interrupt) ints++;
      if (!busy && rd_pend == 0) done = 1;
      else cyc();
    end
    check("t4_drain_done", done, 1);
    check("t4_drain_interrupts", ints, 7);
    check("t4_err_cnt", err_cnt, ERR_EN ? 8 : 0);
    check("t4_ovf_sticky", ovf, 1);

    // Reset asserted while a write is waiting for service.
    do_reset();
    wr_req = 1'b1;
    cyc();
    cyc();
    wr_req = 1'b0;
    cyc();
    cyc();
    check("t5_write_before", write, 1);
    check("t5_wr_pend_before", wr_pend, 1);
    rst_n = 1'b0;
    #1;
    check("t5_write_cleared", write, 0);
    check("t5_interrupt_cleared", interrupt, 0);
    check("t5_wr_pend_cleared", wr_pend, 0);
    check("t5_busy_cleared", busy, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    strobes = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (read || write) strobes++;
    end
    check("t5_no_strobe", strobes, 0);

    // Randomized traffic with random service ages and served noise.
    do_reset();
    resp_en = 1; fix_dly = -1; noise_en = 1;
    for (int i = 0; i < 3000; i++) begin
      int rate;
      rate = (i < 1000) ? 20 : (i < 2000) ? 60 : 8;
      rd_req = ($urandom_range(0, 99) < rate);
      wr_req = ($urandom_range(0, 99) < rate);
      if (i == 1500) rst_n = 1'b0;
      if (i == 1502) rst_n = 1'b1;
      cyc();
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    repeat (200) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
